ram_access_ctrl: RTL and testbench



---
 rtl/ram_access_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ram_access_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Access controller in front of a single-port synchronous RAM: single write, pattern fill, auto-scan read.
// Optional RAM_FILL_VERIFY_EN adds a read-back VERIFY pass after each fill and a sticky fill_err output.
module ram_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int TICK_DIV = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic              start_fill,
  input  logic              start_scan,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_q,
  output logic              busy,
  output logic [1:0]        state
`ifdef RAM_FILL_VERIFY_EN
  ,
  output logic              fill_err
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TICK_DIV);
  localparam logic [ADDR_W:0] LAST   = (ADDR_W+1)'(DEPTH-1);
  localparam logic [TW-1:0]   T_LAST = TW'(TICK_DIV-1);

`ifdef RAM_FILL_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_FILL, S_SCAN, S_VERIFY} st_t;
  localparam logic [ADDR_W:0] V_END = (ADDR_W+1)'(DEPTH);
`else
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FILL, S_SCAN} st_t;
`endif

  st_t st, st_nx;
  logic wr_prev, fill_prev, scan_prev, armed;
  logic wr_p, fill_p, scan_p;
  logic [ADDR_W:0]   cnt, cnt_nx;
  logic [TW-1:0]     tick, tick_nx;
  logic [DATA_W-1:0] seed, seed_nx, data_nx;
  logic [ADDR_W-1:0] addr_nx, rd_addr_d;
  logic              wren_nx, rd_valid_d;
`ifdef RAM_FILL_VERIFY_EN
  logic              err_clr, chk;
  logic [DATA_W-1:0] exp_q;
`endif

  // armed masks the first cycle after reset so a level held across reset is not seen as an edge
  assign wr_p   = armed & wr_req     & ~wr_prev;
  assign fill_p = armed & start_fill & ~fill_prev;
  assign scan_p = armed & start_scan & ~scan_prev;

  always_comb begin
    st_nx   = st;
    addr_nx = ram_addr;
    data_nx = ram_data;
    wren_nx = 1'b0;
    cnt_nx  = cnt;
    tick_nx = tick;
    seed_nx = seed;
`ifdef RAM_FILL_VERIFY_EN
    err_clr = 1'b0;
`endif
    case (st)
      S_IDLE: begin
        addr_nx = addr_in;
        if (wr_p) begin
          st_nx   = S_WRITE;
          data_nx = data_in;
          wren_nx = 1'b1;
        end else if (fill_p) begin
          // first fill write is issued on the entry edge so wren lines up with FILL
          st_nx   = S_FILL;
          seed_nx = data_in;
          cnt_nx  = '0;
          addr_nx = '0;
          data_nx = data_in;
          wren_nx = 1'b1;
`ifdef RAM_FILL_VERIFY_EN
          err_clr = 1'b1;
`endif
        end else if (scan_p) begin
          st_nx   = S_SCAN;
          addr_nx = '0;
          tick_nx = '0;
        end
      end
      S_WRITE: begin
        st_nx   = S_IDLE;
        addr_nx = addr_in;
      end
      S_FILL: begin
        if (cnt == LAST) begin
`ifdef RAM_FILL_VERIFY_EN
          st_nx   = S_VERIFY;
          cnt_nx  = '0;
          addr_nx = '0;
`else
          st_nx   = S_IDLE;
          addr_nx = addr_in;
`endif
        end else begin
          cnt_nx  = cnt + 1'b1;
          addr_nx = ADDR_W'(cnt + 1'b1);
          data_nx = seed + DATA_W'(cnt + 1'b1);
          wren_nx = 1'b1;
        end
      end
      S_SCAN: begin
        if (scan_p) begin
          st_nx   = S_IDLE;
          addr_nx = addr_in;
        end else if (tick == T_LAST) begin
          tick_nx = '0;
          addr_nx = ram_addr + 1'b1;
        end else begin
          tick_nx = tick + 1'b1;
        end
      end
`ifdef RAM_FILL_VERIFY_EN
      // one extra cycle past the last address lets its read data be compared
      S_VERIFY: begin
        if (cnt == V_END) begin
          st_nx   = S_IDLE;
          addr_nx = addr_in;
        end else begin
          cnt_nx  = cnt + 1'b1;
          addr_nx = ADDR_W'(cnt + 1'b1);
        end
      end
`endif
      default: st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    state = 2'd0;
    busy  = 1'b0;
    case (st)
      S_IDLE:   state = 2'd0;
      S_WRITE:  begin state = 2'd1; busy = 1'b1; end
      S_FILL:   begin state = 2'd2; busy = 1'b1; end
      S_SCAN:   state = 2'd3;
`ifdef RAM_FILL_VERIFY_EN
      S_VERIFY: begin state = 2'd1; busy = 1'b1; end
`endif
      default:  state = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= S_IDLE;
      wr_prev    <= 1'b0;
      fill_prev  <= 1'b0;
      scan_prev  <= 1'b0;
      armed      <= 1'b0;
      cnt        <= '0;
      tick       <= '0;
      seed       <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      ram_wren   <= 1'b0;
      rd_addr_d  <= '0;
      rd_valid_d <= 1'b0;
      disp_addr  <= '0;
      disp_q     <= '0;
    end else begin
      st         <= st_nx;
      wr_prev    <= wr_req;
      fill_prev  <= start_fill;
      scan_prev  <= start_scan;
      armed      <= 1'b1;
      cnt        <= cnt_nx;
      tick       <= tick_nx;
      seed       <= seed_nx;
      ram_addr   <= addr_nx;
      ram_data   <= data_nx;
      ram_wren   <= wren_nx;
      rd_addr_d  <= ram_addr;
      rd_valid_d <= ~ram_wren;
      if (rd_valid_d) begin
        disp_addr <= rd_addr_d;
        disp_q    <= q;
      end
    end
  end

`ifdef RAM_FILL_VERIFY_EN
  assign exp_q = seed + DATA_W'(rd_addr_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      chk      <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      chk <= (st == S_VERIFY) && !cnt[ADDR_W];
      if (err_clr)                  fill_err <= 1'b0;
      else if (chk && (q != exp_q)) fill_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: behavioural RAM plus an expected-contents array and
// closed-form expectations for write, fill, scan timing, edge priority and mid-operation reset.
module tb_ram_access_ctrl;
  localparam int AW = 5, DW = 8, TD = 4, DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, wr_req, start_fill, start_scan;
  logic [AW-1:0] addr_in, ram_addr, disp_addr;
  logic [DW-1:0] data_in, q, ram_data, disp_q;
  logic ram_wren, busy;
  logic [1:0] state;
`ifdef RAM_FILL_VERIFY_EN
  logic fill_err;
  localparam int FILL_BUSY = 2*DEPTH + 1;
`else
  localparam int FILL_BUSY = DEPTH;
`endif

  ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TICK_DIV(TD)) dut (
    .clock(clk), .reset(reset), .wr_req(wr_req), .start_fill(start_fill), .start_scan(start_scan),
    .addr_in(addr_in), .data_in(data_in), .q(q), .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_wren(ram_wren), .disp_addr(disp_addr), .disp_q(disp_q), .busy(busy), .state(state)
`ifdef RAM_FILL_VERIFY_EN
    , .fill_err(fill_err)
`endif
  );

  // board RAM: registered read of the previously sampled address; corrupt7 fakes a bad cell
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  logic corrupt7 = 1'b0;
  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    q <= (corrupt7 && ram_addr == 5'd7) ? ~mem[ram_addr] : mem[ram_addr];
  end

  int errors = 0, checks = 0;

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      cyc();
      wr_req = 1'($urandom); start_fill = 1'($urandom); start_scan = 1'($urandom);
      addr_in = AW'($urandom); data_in = DW'($urandom);
    end
    checks++; if (ram_addr !== '0)  begin errors++; $display("FAIL reset_ram_addr: got %h want 0", ram_addr); end
    checks++; if (ram_data !== '0)  begin errors++; $display("FAIL reset_ram_data: got %h want 0", ram_data); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_ram_wren: got %b want 0", ram_wren); end
    checks++; if (disp_addr !== '0) begin errors++; $display("FAIL reset_disp_addr: got %h want 0", disp_addr); end
    checks++; if (disp_q !== '0)    begin errors++; $display("FAIL reset_disp_q: got %h want 0", disp_q); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (state !== 2'd0)   begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    wr_req = 1'b1; start_fill = 1'b0; start_scan = 1'b0;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++;
      if (ram_wren !== 1'b0 || state !== 2'd0)
        begin errors++; $display("FAIL reset_held_wr: cycle %0d got wren=%b state=%0d want 0/0", i, ram_wren, state); end
    end
    wr_req = 1'b0;
    cyc();
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int nw = 0;
    wr_req = 1'b0; cyc();
    addr_in = a; data_in = d; wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (ram_wren === 1'b1) begin
        nw++;
        checks++;
        if (ram_addr !== a || ram_data !== d || state !== 2'd1 || busy !== 1'b1)
          begin errors++; $display("FAIL write_bus: got %h/%h st=%0d busy=%b want %h/%h st=1 busy=1", ram_addr, ram_data, state, busy, a, d); end
      end
    end
    checks++; if (nw != 1) begin errors++; $display("FAIL write_count: got %0d wren cycles want 1", nw); end
    exp_mem[a] = d;
    wr_req = 1'b0;
    cyc(4);
    checks++;
    if (disp_addr !== a || disp_q !== exp_mem[a])
      begin errors++; $display("FAIL write_readback: got %h/%h want %h/%h", disp_addr, disp_q, a, exp_mem[a]); end
  endtask

  task automatic test_fill(input logic [DW-1:0] seed, input logic exp_err);
    int nw = 0, nbusy = 0, first = -1, last = -1;
    logic [DW-1:0] e;
    start_fill = 1'b0; cyc();
    data_in = seed; start_fill = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (busy === 1'b1) nbusy++;
      if (ram_wren === 1'b1) begin
        e = seed + DW'(nw);
        checks++;
        if (ram_addr !== AW'(nw) || ram_data !== e)
          begin errors++; $display("FAIL fill_word: got %h/%h want %h/%h", ram_addr, ram_data, AW'(nw), e); end
        if (first < 0) first = i;
        last = i;
        nw++;
      end
    end
    checks++; if (nw != DEPTH) begin errors++; $display("FAIL fill_count: got %0d want %0d", nw, DEPTH); end
    checks++; if (last - first + 1 != nw) begin errors++; $display("FAIL fill_contig: span %0d want %0d", last - first + 1, nw); end
    checks++; if (nbusy != FILL_BUSY) begin errors++; $display("FAIL fill_busy: got %0d want %0d", nbusy, FILL_BUSY); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL fill_end_state: got %0d want 0", state); end
`ifdef RAM_FILL_VERIFY_EN
    checks++; if (fill_err !== exp_err) begin errors++; $display("FAIL fill_err: got %b want %b", fill_err, exp_err); end
`else
    if (exp_err) $display("note: fill_err not present in this build");
`endif
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = seed + DW'(k);
    start_fill = 1'b0;
  endtask

  task automatic test_scan();
    logic [AW-1:0] ea, da;
    start_scan = 1'b0; cyc();
    start_scan = 1'b1;
    for (int n = 0; n < 140; n++) begin
      cyc();
      ea = AW'((n / TD) % DEPTH);
      checks++;
      if (state !== 2'd3 || ram_addr !== ea || ram_wren !== 1'b0)
        begin errors++; $display("FAIL scan_addr: n=%0d got st=%0d addr=%h wren=%b want 3/%h/0", n, state, ram_addr, ram_wren, ea); end
      if (n >= 2) begin
        da = AW'(((n - 2) / TD) % DEPTH);
        checks++;
        if (disp_addr !== da || disp_q !== exp_mem[da])
          begin errors++; $display("FAIL scan_disp: n=%0d got %h/%h want %h/%h", n, disp_addr, disp_q, da, exp_mem[da]); end
      end
      if (n == 1)  start_scan = 1'b0;
      if (n == 50) wr_req = 1'b1;
      if (n == 54) wr_req = 1'b0;
      if (n == 70) start_fill = 1'b1;
      if (n == 74) start_fill = 1'b0;
    end
    start_scan = 1'b1;
    cyc();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL scan_exit: got %0d want 0", state); end
    start_scan = 1'b0;
    cyc();
  endtask

  task automatic test_simul();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int nw = 0;
    a = AW'($urandom); d = DW'($urandom);
    wr_req = 1'b0; start_fill = 1'b0; cyc();
    addr_in = a; data_in = d; wr_req = 1'b1; start_fill = 1'b1;
    cyc();
    checks++;
    if (state !== 2'd1 || ram_wren !== 1'b1 || ram_addr !== a || ram_data !== d)
      begin errors++; $display("FAIL simul_write: got st=%0d wren=%b %h/%h want 1/1 %h/%h", state, ram_wren, ram_addr, ram_data, a, d); end
    cyc();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL simul_idle: got %0d want 0", state); end
    for (int i = 0; i < 6; i++) begin cyc(); if (ram_wren === 1'b1 || state !== 2'd0) nw++; end
    checks++; if (nw != 0) begin errors++; $display("FAIL simul_dropped_fill: got %0d active cycles want 0", nw); end
    exp_mem[a] = d;
    wr_req = 1'b0; start_fill = 1'b0;
  endtask

  task automatic test_reset_mid_fill(input logic [DW-1:0] seed);
    logic found = 1'b0;
    int nw = 0;
    start_fill = 1'b0; cyc();
    data_in = seed; start_fill = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (ram_wren === 1'b1 && ram_addr === 5'd10) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midfill_reach: got no write at addr 0a want one"); end
    reset = 1'b1;
    cyc();
    checks++;
    if (ram_wren !== 1'b0 || state !== 2'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL midfill_abort: got wren=%b st=%0d busy=%b want 0/0/0", ram_wren, state, busy); end
    reset = 1'b0; start_fill = 1'b0;
    for (int k = 0; k <= 10; k++) exp_mem[k] = seed + DW'(k);
    for (int i = 0; i < 40; i++) begin cyc(); if (ram_wren === 1'b1) nw++; end
    checks++; if (nw != 0) begin errors++; $display("FAIL midfill_resume: got %0d writes want 0", nw); end
  endtask

  task automatic test_readback();
    logic [AW-1:0] a;
    for (int k = 0; k < 8; k++) begin
      a = (k == 0) ? AW'(10) : (k == 1) ? AW'(11) : AW'($urandom);
      addr_in = a;
      cyc(4);
      checks++;
      if (disp_addr !== a || disp_q !== exp_mem[a])
        begin errors++; $display("FAIL readback: got %h/%h want %h/%h", disp_addr, disp_q, a, exp_mem[a]); end
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin mem[k] = '0; exp_mem[k] = '0; end
    q = '0;
    reset = 1'b1; wr_req = 1'b0; start_fill = 1'b0; start_scan = 1'b0;
    addr_in = '0; data_in = '0;
    test_reset();
    test_write(5'h0A, 8'h3C);
    repeat (3) test_write(AW'($urandom), DW'($urandom));
`ifdef RAM_FILL_VERIFY_EN
    corrupt7 = 1'b1;
    test_fill(DW'($urandom), 1'b1);
    corrupt7 = 1'b0;
`endif
    test_fill(8'hF8, 1'b0);
    test_scan();
    test_simul();
    test_fill(DW'($urandom), 1'b0);
    test_reset_mid_fill(DW'($urandom));
    test_readback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
